// File: rtl/fc_pkg.sv
// =============================================================================
// Package     : fc_pkg
// Description : Shared types and helpers for the sequential fully connected
//               layer: FSM state encoding, signed saturation and the minimum
//               accumulator width needed to hold a full dot product.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package fc_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        MAC            = 3'd1,
        DRAIN          = 3'd2,
        WRITE          = 3'd3,
        DONE           = 3'd4,
        WAIT_START_LOW = 3'd5
    } fc_state_t;

    // Working width of the saturation helper; accumulators are sign-extended
    // up to this before clamping.
    localparam int c_SAT_W = 128;

    // Smallest accumulator that can hold bias + N_IN products without wrap.
    function automatic int acc_w_min(input int in_w, input int w_w, input int n_in);
        return in_w + w_w + $clog2(n_in) + 1;
    endfunction

    // Clamp a signed value into the signed range of out_w bits.
    function automatic logic signed [c_SAT_W-1:0] sat_s(
        input logic signed [c_SAT_W-1:0] acc,
        input int                        out_w
    );
        logic signed [c_SAT_W-1:0] w_max;
        logic signed [c_SAT_W-1:0] w_min;
        w_max = '1;
        w_max = w_max >> (c_SAT_W - out_w + 1);   // 2^(out_w-1)-1
        w_min = ~w_max;                            // -2^(out_w-1)
        if (acc > w_max) begin
            return w_max;
        end else if (acc < w_min) begin
            return w_min;
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_mac_lanes.sv
// =============================================================================
// Module      : fc_mac_lanes
// Description : LANES signed multipliers feeding one adder, purely
//               combinational. Produces the partial dot product of one ROM
//               word worth of weights against the matching activations.
// Ports       : i_act  - LANES signed activations, IN_W bits each
//               i_wt   - LANES signed weights, W_W bits each
//               o_psum - signed partial sum, ACC_W bits
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fc_mac_lanes #(
    parameter int LANES = 4,
    parameter int IN_W  = 32,
    parameter int W_W   = 8,
    parameter int ACC_W = 48
) (
    input  logic [LANES-1:0][IN_W-1:0] i_act,
    input  logic [LANES-1:0][W_W-1:0]  i_wt,
    output logic signed [ACC_W-1:0]    o_psum
);

    logic signed [ACC_W-1:0] w_prod [LANES];

    // Operands are sign-extended to ACC_W first, so the truncated product is
    // exact (ACC_W is checked to exceed IN_W+W_W at the top level).
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_prod[l] = ACC_W'($signed(i_act[l])) * ACC_W'($signed(i_wt[l]));
    end

    always_comb begin
        o_psum = '0;
        for (int l = 0; l < LANES; l++) begin
            o_psum = o_psum + w_prod[l];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_layer_seq.sv
// =============================================================================
// Module      : fc_layer_seq
// Description : Time-multiplexed fully connected layer,
//               out[j] = sat(bias[j] + sum_i act[i]*W[j][i]) with optional
//               ReLU. Weights stream from an external synchronous ROM, one
//               LANES-wide word per cycle.
// Ports       : clk, reset        - clock / asynchronous active-high reset
//               start             - level request, accepted only when idle
//               busy, done        - run status
//               act, bias         - operands, held stable while busy
//               w_addr, w_rd      - ROM address and read strobe
//               w_rdata           - ROM word, valid the cycle after w_rd
//               out_we, out_idx,
//               out_data          - one strobe per finished neuron
//               fc_output         - registered result array
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fc_layer_seq
    import fc_pkg::*;
#(
    parameter  int N_IN    = 128,
    parameter  int N_OUT   = 10,
    parameter  int LANES   = 4,
    parameter  int IN_W    = 32,
    parameter  int W_W     = 8,
    parameter  int B_W     = 32,
    parameter  int ACC_W   = 48,
    parameter  int OUT_W   = 32,
    parameter  int RELU_EN = 0,
    localparam int c_K      = N_IN / LANES,
    localparam int c_ADDR_W = (N_OUT * c_K > 1) ? $clog2(N_OUT * c_K) : 1,
    localparam int c_IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic [N_IN-1:0][IN_W-1:0]        act,
    input  logic [N_OUT-1:0][B_W-1:0]        bias,
    output logic [c_ADDR_W-1:0]              w_addr,
    output logic                             w_rd,
    input  logic [LANES-1:0][W_W-1:0]        w_rdata,
    output logic                             out_we,
    output logic [c_IDX_W-1:0]               out_idx,
    output logic [OUT_W-1:0]                 out_data,
    output logic [N_OUT-1:0][OUT_W-1:0]      fc_output
);

    localparam int c_KW       = (c_K > 1) ? $clog2(c_K) : 1;
    localparam int c_ROW_BITS = LANES * IN_W;

    if (N_IN % LANES != 0) begin : g_chk_lanes
        $error("fc_layer_seq: N_IN must be a multiple of LANES");
    end
    if (ACC_W < acc_w_min(IN_W, W_W, N_IN)) begin : g_chk_acc
        $error("fc_layer_seq: ACC_W too small for a full dot product");
    end

    fc_state_t               r_state;
    logic [c_IDX_W-1:0]      r_j;      // neuron being computed
    logic [c_KW-1:0]         r_ka;     // word index currently on w_addr
    logic                    r_vld;    // w_rdata holds a requested word
    logic [c_KW-1:0]         r_vk;     // word index of that returning data
    logic signed [ACC_W-1:0] r_acc;

    logic [N_IN*IN_W-1:0]         w_act_sh;
    logic [LANES-1:0][IN_W-1:0]   w_act_lanes;
    logic signed [ACC_W-1:0]      w_psum;
    logic [OUT_W-1:0]             w_res;

    // Select the activation slice matching the word coming back from the ROM.
    assign w_act_sh    = act >> (r_vk * c_ROW_BITS);
    assign w_act_lanes = w_act_sh[c_ROW_BITS-1:0];

    fc_mac_lanes #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_act  (w_act_lanes),
        .i_wt   (w_rdata),
        .o_psum (w_psum)
    );

    always_comb begin
        w_res = OUT_W'(sat_s(c_SAT_W'(r_acc), OUT_W));
        if ((RELU_EN != 0) && w_res[OUT_W-1]) begin
            w_res = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_j       <= '0;
            r_ka      <= '0;
            r_vld     <= 1'b0;
            r_vk      <= '0;
            r_acc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_rd      <= 1'b0;
            w_addr    <= '0;
            out_we    <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            fc_output <= '0;
        end else begin
            out_we <= 1'b0;
            r_vld  <= w_rd;
            r_vk   <= r_ka;
            // Words only return during MAC/DRAIN, never on a cycle that
            // reloads the accumulator, so the case below cannot collide.
            if (r_vld) begin
                r_acc <= r_acc + w_psum;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= MAC;
                        r_j     <= '0;
                        r_ka    <= '0;
                        w_addr  <= '0;
                        w_rd    <= 1'b1;
                        r_acc   <= ACC_W'($signed(bias[0]));
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                MAC: begin
                    if (r_ka == c_KW'(c_K - 1)) begin
                        w_rd    <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_ka   <= r_ka + c_KW'(1);
                        w_addr <= w_addr + c_ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    r_state <= WRITE;
                end
                WRITE: begin
                    fc_output[r_j] <= w_res;
                    out_we         <= 1'b1;
                    out_idx        <= r_j;
                    out_data       <= w_res;
                    if (r_j == c_IDX_W'(N_OUT - 1)) begin
                        r_state <= DONE;
                    end else begin
                        // Addresses are contiguous across neurons (j*K+k).
                        r_j     <= r_j + c_IDX_W'(1);
                        r_ka    <= '0;
                        w_addr  <= w_addr + c_ADDR_W'(1);
                        w_rd    <= 1'b1;
                        r_acc   <= ACC_W'($signed(bias[r_j + c_IDX_W'(1)]));
                        r_state <= MAC;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= WAIT_START_LOW;
                end
                WAIT_START_LOW: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
